uart_tx_scheduler: RTL
======================

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_SRC, default 4, giving the number of byte-stream requesters (2..8).
REQ-002 The block SHALL have parameter MAX_LEN, default 16, giving the maximum payload bytes per packet (1..255).
REQ-003 The block SHALL have parameter HDR_TAG, default 4'hA, giving the upper nibble of every header byte.
REQ-004 The block SHALL have port clk_in, input, 1, the single system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_in, input, 1, the reset; it is synchronous and active-high.
REQ-006 The block SHALL have port src_valid_in, input, NUM_SRC, one bit per source: a payload byte is offered.
REQ-007 The block SHALL have port src_data_in, input, NUM_SRC*8, with the byte for source i in bits [8i+7:8i].
REQ-008 The block SHALL have port src_last_in, input, NUM_SRC, marking the offered byte as the packet's final byte.
REQ-009 The block SHALL have port src_ready_out, output, NUM_SRC, the per-source byte-accepted strobe.
REQ-010 The block SHALL have port grant_out, output, NUM_SRC, one-hot, naming the source that owns the link.
REQ-011 The block SHALL have port tx_data_out, output, 8, the byte presented to the UART transmitter.
REQ-012 The block SHALL have port tx_trigger_out, output, 1, the UART transmitter start strobe.
REQ-013 The block SHALL have port tx_busy_in, input, 1, the UART transmitter busy flag, which rises the cycle after an accepted trigger.
REQ-014 The block SHALL have port busy_out, output, 1, asserted whenever the block is not IDLE.
REQ-015 The block SHALL have port pkt_done_out, output, 1, a one-cycle pulse when a checksum byte finishes.
REQ-016 The block SHALL have port trunc_out, output, 1, a one-cycle pulse coincident with pkt_done_out for a truncated packet.

Function
REQ-017 The block SHALL send each packet on the wire as: header byte {HDR_TAG, 4-bit source index}, then the payload bytes, then one checksum byte equal to the XOR of the payload bytes (initial value 8'h00).
REQ-018 The state machine SHALL have four states: IDLE, ISSUE, LAUNCH and DRAIN, plus a phase register holding HDR, PAY or CSUM.
REQ-019 IDLE: when any src_valid_in bit is 1, the block SHALL register a round-robin winner into grant_out, set phase HDR and go to ISSUE on the next cycle.
REQ-020 Round-robin search SHALL start at last_grant+1 modulo NUM_SRC; last_grant updates only at packet end.
REQ-021 ISSUE: the block SHALL assert tx_trigger_out for exactly one cycle when tx_busy_in==0 and either phase!=PAY or src_valid_in[grant]==1, then go to LAUNCH.
REQ-022 When those conditions do not hold, the block SHALL stay in ISSUE (the source may stall indefinitely).
REQ-023 tx_data_out SHALL be driven as: phase HDR gives the header byte; phase PAY gives src_data_in of the granted source, combinationally; phase CSUM gives the checksum register.
REQ-024 src_ready_out[grant] SHALL equal tx_trigger_out while phase==PAY; all other bits of src_ready_out SHALL be 0 at all times.
REQ-025 On each PAY trigger the block SHALL XOR the byte into the checksum, increment the byte count, and register src_last_in[grant].
REQ-026 LAUNCH SHALL last exactly one cycle, during which tx_busy_in is ignored; the block then goes to DRAIN.
REQ-027 DRAIN: the block SHALL wait until tx_busy_in==0, then advance as follows:
  - phase HDR goes to PAY;
  - phase PAY with last set goes to CSUM;
  - phase PAY with count==MAX_LEN goes to CSUM and flags truncation;
  - any other PAY byte stays in PAY;
  - each of these returns to ISSUE;
  - phase CSUM pulses pkt_done_out (and trunc_out when truncation was flagged), updates last_grant, clears grant_out, checksum and count, and goes to IDLE.
REQ-028 A byte with last set arriving at count==MAX_LEN-1 SHALL end the packet normally, without truncation.
REQ-029 After truncation, the source's following bytes SHALL start a new packet with a new header.
REQ-030 Minimum latency SHALL be: src_valid_in high in IDLE at cycle T gives tx_trigger_out for the header at T+1.
REQ-031 grant_out SHALL be constant from the cycle after IDLE until the cycle after the pkt_done_out pulse; a change in src_valid_in of a non-granted source SHALL NOT preempt the packet.

Reset
REQ-032 While rst_in=1 the block SHALL set state to IDLE, phase to HDR, and grant_out, checksum, count, pkt_done_out, trunc_out and tx_trigger_out to 0.
REQ-033 While rst_in=1 the block SHALL set last_grant to NUM_SRC-1, so that source 0 wins first after reset.
REQ-034 Reset mid-packet SHALL abandon the packet with no checksum sent; a byte already inside the transmitter is the transmitter's own reset concern.

Structure
REQ-035 The state enum, the phase enum and the header-byte construction function SHALL live in shared package uart_sched_pkg.
REQ-036 The block SHALL contain one sub-module, rr_arbiter (request vector plus last-grant pointer to one-hot grant), which is combinational and parameterized by NUM_SRC.
REQ-037 uart_tx_scheduler SHALL instantiate the existing UART transmitter only in the testbench, not inside itself.

Verification
REQ-038 The bench SHALL cover: after reset, source 2 sends 8'h11, 8'h22 (last) -> wire carries A2, 11, 22, 33; pkt_done_out=1 once; trunc_out=0.
REQ-039 The bench SHALL cover: sources 0 and 3 both valid from reset -> packet order 0, 3, 0, 3; grant_out never changes mid-packet.
REQ-040 The bench SHALL cover: with MAX_LEN=4, source 1 streams 6 bytes with no last -> packet of 4 bytes with trunc_out pulse, then a new A1 packet carrying the remaining 2 bytes.
REQ-041 The bench SHALL cover: granted source drops valid for 50 cycles mid-packet -> tx_trigger_out stays 0, no src_ready_out, and the packet resumes intact.
REQ-042 The bench SHALL cover: rst_in pulsed during DRAIN of a payload byte -> next cycle busy_out=0 and grant_out=0, and source 0 wins the next arbitration.
REQ-043 The bench SHALL cover: tx_busy_in held high on entry to ISSUE -> trigger withheld until it falls, with exactly one trigger per byte.

Source files
------------

// File: rtl/uart_sched_pkg.sv
// Shared types for the UART transmit scheduler.
// Holds the FSM/phase encodings and header-byte builder.
package uart_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    LAUNCH,
    DRAIN
  } state_t;

  typedef enum logic [1:0] {
    HDR,
    PAY,
    CSUM
  } phase_t;

  function automatic logic [7:0] hdr_byte(
    input logic [3:0] tag,
    input logic [3:0] idx
  );
    return {tag, idx};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Search starts one past the last granted source.
module rr_arbiter #(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0]         req,
  input  logic [$clog2(NUM_SRC)-1:0] last_ptr,
  output logic [NUM_SRC-1:0]         grant,
  output logic [$clog2(NUM_SRC)-1:0] grant_idx
);

  localparam int IW = $clog2(NUM_SRC);
  localparam logic [IW-1:0] TOP = IW'(NUM_SRC - 1);

  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = (last_ptr == TOP) ? '0 : last_ptr + 1'b1;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!found && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        found       = 1'b1;
      end
      cand = (cand == TOP) ? '0 : cand + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Packetises per-source byte streams onto one UART:
// header, payload, XOR checksum, with round-robin ownership.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int         NUM_SRC = 4,
  parameter int         MAX_LEN = 16,
  parameter logic [3:0] HDR_TAG = 4'hA
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [NUM_SRC-1:0]   src_valid_in,
  input  logic [NUM_SRC*8-1:0] src_data_in,
  input  logic [NUM_SRC-1:0]   src_last_in,
  output logic [NUM_SRC-1:0]   src_ready_out,
  output logic [NUM_SRC-1:0]   grant_out,
  output logic [7:0]           tx_data_out,
  output logic                 tx_trigger_out,
  input  logic                 tx_busy_in,
  output logic                 busy_out,
  output logic                 pkt_done_out,
  output logic                 trunc_out
);

  localparam int IW = $clog2(NUM_SRC);
  localparam logic [7:0] LEN_MAX = 8'(MAX_LEN);

  state_t state, state_nxt;
  phase_t phase;

  logic [IW-1:0]      gidx, last_grant, arb_idx;
  logic [NUM_SRC-1:0] arb_grant;
  logic [7:0]         csum, count, pay_byte;
  logic               last_q, trunc_q;
  logic               g_valid, g_last, fire, drain_go;

  rr_arbiter #(
    .NUM_SRC(NUM_SRC)
  ) u_arb (
    .req      (src_valid_in),
    .last_ptr (last_grant),
    .grant    (arb_grant),
    .grant_idx(arb_idx)
  );

  always_comb begin
    pay_byte = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_out[i]) pay_byte |= src_data_in[8*i +: 8];
    end
  end

  assign g_valid  = |(src_valid_in & grant_out);
  assign g_last   = |(src_last_in & grant_out);
  assign fire     = (state == ISSUE) && !tx_busy_in &&
                    (phase != PAY || g_valid);
  assign drain_go = (state == DRAIN) && !tx_busy_in;

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (|src_valid_in) state_nxt = ISSUE;
      ISSUE:   if (fire) state_nxt = LAUNCH;
      LAUNCH:  state_nxt = DRAIN;
      DRAIN:   if (!tx_busy_in)
                 state_nxt = (phase == CSUM) ? IDLE : ISSUE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are Mealy so the header can launch the cycle after IDLE.
  always_comb begin
    tx_trigger_out = fire && !rst_in;
    src_ready_out  = (phase == PAY && tx_trigger_out) ? grant_out : '0;
    pkt_done_out   = drain_go && (phase == CSUM) && !rst_in;
    trunc_out      = pkt_done_out && trunc_q;
    busy_out       = (state != IDLE);
    tx_data_out    = '0;
    unique case (phase)
      HDR:     tx_data_out = hdr_byte(HDR_TAG, 4'(gidx));
      PAY:     tx_data_out = pay_byte;
      CSUM:    tx_data_out = csum;
      default: tx_data_out = '0;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      phase      <= HDR;
      grant_out  <= '0;
      gidx       <= '0;
      last_grant <= IW'(NUM_SRC - 1);
      csum       <= '0;
      count      <= '0;
      last_q     <= 1'b0;
      trunc_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|src_valid_in) begin
          grant_out <= arb_grant;
          gidx      <= arb_idx;
          phase     <= HDR;
        end
        ISSUE: if (fire && phase == PAY) begin
          csum   <= csum ^ pay_byte;
          count  <= count + 8'd1;
          last_q <= g_last;
        end
        DRAIN: if (!tx_busy_in) begin
          unique case (phase)
            HDR: phase <= PAY;
            // A last byte wins over the length cap.
            PAY: if (last_q) begin
              phase <= CSUM;
            end else if (count == LEN_MAX) begin
              phase   <= CSUM;
              trunc_q <= 1'b1;
            end
            CSUM: begin
              last_grant <= gidx;
              grant_out  <= '0;
              csum       <= '0;
              count      <= '0;
              last_q     <= 1'b0;
              trunc_q    <= 1'b0;
              phase      <= HDR;
            end
            default: phase <= HDR;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule
